// File: rtl/fetch_fifo_pkg.sv
// Shared constants and helpers for the fetch line FIFO.
// Holds the default word geometry and the pointer-width function
// used by both the line (write) and word (read) pointer counters.
package fetch_fifo_pkg;

  localparam int FETCH_WORD_W = 32;
  localparam int FETCH_WORDS  = 4;

  // Width of a pointer addressing n entries plus one wrap bit.
  function automatic int ptr_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer counter with synchronous flush and enable.
// The counter wraps naturally modulo 2**W; flush wins over enable.
module fifo_ptr_cnt #(
  parameter int W    = 3,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         en,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] STEP_L = W'(STEP);

  // Advance by STEP when enabled; flush and async reset return to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + STEP_L;
    end
  end

endmodule

// File: rtl/fetch_line_fifo.sv
// Fetch line FIFO: written one line (WORDS words) at a time, read one
// word at a time with first-word fall-through.
// Optional feature macro: FETCH_LINE_FIFO_ERR_EN adds sticky overflow and
// underflow error outputs.
// A line slot stays occupied until its last word has been popped, so
// fullness is decoded from the line index of the read pointer.
module fetch_line_fifo
  import fetch_fifo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WORD_W  = FETCH_WORD_W,
  parameter int WORDS   = FETCH_WORDS,
  parameter int AF_FREE = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  logic                              i_wr_en,
  input  logic [WORD_W*WORDS-1:0]           i_wr_data,
  input  logic                              i_rd_en,
  output logic [WORD_W-1:0]                 o_rd_data,
  output logic                              o_empty,
  output logic                              o_full,
  output logic                              o_afull,
  output logic [$clog2(DEPTH*WORDS):0]      o_count
`ifdef FETCH_LINE_FIFO_ERR_EN
  ,
  output logic                              o_ovf_err,
  output logic                              o_udf_err
`endif
);

  localparam int LINE_W = WORD_W * WORDS;
  localparam int LPW    = ptr_w(DEPTH);          // line pointer width
  localparam int RPW    = ptr_w(DEPTH * WORDS);  // word pointer width
  localparam int WB     = $clog2(WORDS);         // word-in-line bits
  localparam int AW     = LPW - 1;               // slot index bits

  localparam logic [LPW-1:0] DEPTH_L = LPW'(DEPTH);
  localparam logic [LPW-1:0] AF_L    = LPW'(AF_FREE);

  logic [LINE_W-1:0] mem [DEPTH];

  logic [LPW-1:0]    wp;
  logic [RPW-1:0]    rp;
  logic [LPW-1:0]    rp_line;
  logic [LPW-1:0]    used_lines;
  logic [LINE_W-1:0] head_line;
  logic [WB-1:0]     head_word;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come only from registered pointers, so acceptance never
  // depends on the same-cycle opposite request.
  assign wr_acc = i_wr_en & ~o_full & ~i_flush;
  assign rd_acc = i_rd_en & ~o_empty & ~i_flush;

  fifo_ptr_cnt #(.W(LPW), .STEP(1)) u_wp (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_flush),
    .en    (wr_acc),
    .ptr   (wp)
  );

  fifo_ptr_cnt #(.W(RPW), .STEP(1)) u_rp (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_flush),
    .en    (rd_acc),
    .ptr   (rp)
  );

  // Line storage; not reset, contents are meaningless once pointers clear.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wp[AW-1:0]] <= i_wr_data;
    end
  end

  // Decode occupancy flags, word count and the head word.
  always_comb begin
    rp_line    = rp[RPW-1:WB];
    head_word  = rp[WB-1:0];
    used_lines = wp - rp_line;
    o_full     = (used_lines == DEPTH_L);
    o_afull    = ((DEPTH_L - used_lines) <= AF_L);
    o_count    = {wp, {WB{1'b0}}} - rp;
    o_empty    = (o_count == '0);
    head_line  = mem[rp_line[AW-1:0]];
    o_rd_data  = '0;
    if (!o_empty) begin
      o_rd_data = head_line[int'(head_word) * WORD_W +: WORD_W];
    end
  end

`ifdef FETCH_LINE_FIFO_ERR_EN
  // Sticky error flags for dropped writes and ignored reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf_err <= 1'b0;
      o_udf_err <= 1'b0;
    end else if (i_flush) begin
      o_ovf_err <= 1'b0;
      o_udf_err <= 1'b0;
    end else begin
      if (i_wr_en && o_full) begin
        o_ovf_err <= 1'b1;
      end
      if (i_rd_en && o_empty) begin
        o_udf_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_fifo.sv
// Self-checking bench for fetch_line_fifo (default parameters).
// Stimulus pushes expected words into a queue; a monitor pops and
// compares whenever the DUT pops a word.
module tb_fetch_line_fifo;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         wr_en;
  logic [127:0] wr_data;
  logic         rd_en;
  logic [31:0]  rd_data;
  logic         empty;
  logic         full;
  logic         afull;
  logic [4:0]   count;
`ifdef FETCH_LINE_FIFO_ERR_EN
  logic         ovf_err;
  logic         udf_err;
`endif

  int tests;
  int fails;
  int wl;            // lines accepted since last clear
  int rw;            // words popped since last clear
  logic [31:0] exp_q[$];

  fetch_line_fifo #(.DEPTH(4), .WORD_W(32), .WORDS(4), .AF_FREE(1)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_afull   (afull),
    .o_count   (count)
`ifdef FETCH_LINE_FIFO_ERR_EN
    ,
    .o_ovf_err (ovf_err),
    .o_udf_err (udf_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input int n);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hC000_0000 + 32'(n * 256 + k);
    return l;
  endfunction

  // Monitor: compare every popped word with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_en && !flush && !empty) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_data: got 0x%0h, expected no word available", rd_data);
      end else begin
        if (rd_data !== exp_q[0]) begin
          fails++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus, model update and flag comparison.
  task automatic step(input logic wr, input logic [127:0] d, input logic rd, input logic fl);
    bit m_full, m_empty;
    int used;
    m_full  = ((wl - rw / 4) == 4);
    m_empty = (wl * 4 == rw);
    wr_en = wr; wr_data = d; rd_en = rd; flush = fl;
    if (fl) begin
      wl = 0; rw = 0; exp_q.delete();
    end else begin
      if (wr && !m_full) begin
        wl++;
        for (int k = 0; k < 4; k++) exp_q.push_back(d[k*32 +: 32]);
      end
      if (rd && !m_empty) rw++;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    used = wl - rw / 4;
    chk("model_count", 64'(count), 64'(wl * 4 - rw));
    chk("model_empty", 64'(empty), 64'(wl * 4 == rw));
    chk("model_full",  64'(full),  64'(used == 4));
    chk("model_afull", 64'(afull), 64'((4 - used) <= 1));
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    tests = 0; fails = 0; wl = 0; rw = 0;
    rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data",  64'(rd_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single line, fall-through, four pops.
    step(1'b1, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b0, 1'b0);
    chk("l1_count", 64'(count), 64'd4);
    chk("l1_data",  64'(rd_data), 64'h1111_1111);
    reads(1);
    chk("l1_data2", 64'(rd_data), 64'h2222_2222);
    reads(3);
    chk("l1_empty", 64'(empty), 64'd1);
    chk("l1_zero",  64'(rd_data), 64'd0);

    // Read while empty is ignored.
    step(1'b0, '0, 1'b1, 1'b0);
    chk("udf_count", 64'(count), 64'd0);
`ifdef FETCH_LINE_FIFO_ERR_EN
    chk("udf_err", 64'(udf_err), 64'd1);
`endif

    // Fill to full, then overflow.
    for (int n = 0; n < 4; n++) begin
      step(1'b1, line_of(n), 1'b0, 1'b0);
      if (n == 2) begin
        chk("fill3_afull", 64'(afull), 64'd1);
        chk("fill3_full",  64'(full),  64'd0);
        chk("fill3_count", 64'(count), 64'd12);
      end
    end
    chk("fill4_full",  64'(full),  64'd1);
    chk("fill4_count", 64'(count), 64'd16);
    step(1'b1, line_of(9), 1'b0, 1'b0);
    chk("ovf_count", 64'(count), 64'd16);
`ifdef FETCH_LINE_FIFO_ERR_EN
    chk("ovf_err", 64'(ovf_err), 64'd1);
`endif

    // Full: read plus write, write dropped.
    step(1'b1, line_of(10), 1'b1, 1'b0);
    chk("rdwr_full",  64'(full),  64'd1);
    chk("rdwr_count", 64'(count), 64'd15);
    reads(3);
    chk("free_full",  64'(full),  64'd0);
    chk("free_count", 64'(count), 64'd12);
    chk("free_data",  64'(rd_data), 64'hC000_0100);
    reads(12);
    chk("drain_empty", 64'(empty), 64'd1);

    // Mid-line simultaneous read and write.
    step(1'b1, line_of(20), 1'b0, 1'b0);
    reads(2);
    chk("mid_count2", 64'(count), 64'd2);
    step(1'b1, line_of(21), 1'b1, 1'b0);
    chk("mid_count5", 64'(count), 64'd5);
    chk("mid_data",   64'(rd_data), 64'hC000_1403);
    reads(5);
    chk("mid_empty", 64'(empty), 64'd1);

    // Pointer wrap: 12 lines, 48 pops interleaved.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, line_of(30 + i), (i > 0), 1'b0);
      reads(3);
    end
    reads(4);
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("wrap_queue", 64'(exp_q.size()), 64'd0);

    // Flush with concurrent write.
    step(1'b1, line_of(50), 1'b0, 1'b0);
    step(1'b1, line_of(51), 1'b0, 1'b0);
    chk("fl_count8", 64'(count), 64'd8);
    step(1'b1, line_of(52), 1'b0, 1'b1);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_data",  64'(rd_data), 64'd0);

    // Async reset mid-read, no clock edge before the check.
    step(1'b1, line_of(60), 1'b0, 1'b0);
    reads(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_data",  64'(rd_data), 64'd0);
    chk("arst_full",  64'(full),  64'd0);
    wl = 0; rw = 0; exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal operation after reset.
    step(1'b1, line_of(70), 1'b0, 1'b0);
    chk("post_data", 64'(rd_data), 64'hC000_4600);
    reads(4);
    chk("post_empty", 64'(empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
